im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Byte-stream program loader; drives the instruction-memory load port: the write-enable/command, byte address and byte data inputs.
- Accepts a framed byte stream over a valid/ready handshake: length byte, payload, then an optional checksum byte.
- Writes the payload to consecutive instruction-memory addresses while holding the CPU off through the command line.
- Sits between the host/UART byte source and the instruction memory at top level.

Parameters:
- BASE_ADDR, 8'h00, first instruction-memory byte address written; address wraps mod 256.
- ADDR_W, 8, instruction-memory byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- s_valid  in  1  source byte valid.
- s_data  in  8  source byte.
- s_ready  out  1  loader can accept a byte.
- o_inCmd  out  1  load command to instruction memory; memory writes o_inst to o_addr on every clk edge while high.
- o_addr  out  ADDR_W  memory byte address.
- o_inst  out  8  memory byte data.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse at load end.
- o_err  out  1  sticky checksum error, cleared by start.

Behaviour:
- All outputs are registered.
- Reset (rst low, async): state IDLE, o_inCmd=0, o_addr=BASE_ADDR, o_inst=8'hFF, count=0, sum=0, s_ready=0, o_busy=0, o_done=0, o_err=0.
- Reset mid-load drops o_inCmd immediately. Partial memory contents are left as written.
- A byte transfers on an edge where s_valid && s_ready. s_data must be stable while s_valid=1 && s_ready=0.
- s_ready=1 only in LEN, DATA and CSUM.
- IDLE: start -> LEN and clear o_err. start is ignored in every other state.
- LEN: accepted byte L sets remaining = (L==0) ? 256 : L, using a 9-bit counter. Go to DATA.
- DATA, on an accepted byte:
  - First byte: o_addr=BASE_ADDR.
  - Later bytes: o_addr=o_addr+1, mod 256 wrap.
  - o_inst=s_data, o_inCmd=1, sum=sum+s_data (mod 256), remaining decrements.
  - When remaining reaches 0: go to CSUM if the feature is enabled, else FLUSH.
- Write timing: o_addr and o_inst change only on the edge that accepts a byte, so repeated writes of the same byte to the same address between accepts are harmless.
- Each byte is written on the edge after its accept.
- CSUM: s_ready=1 and o_inCmd stays 1. The accepted byte is compared to sum; mismatch sets o_err. Go to FLUSH.
- FLUSH: exactly one cycle with o_inCmd=1. This guarantees the final byte is written. Go to DONE.
- DONE: o_inCmd=0, o_done=1 for one cycle, then IDLE. o_addr holds the last written address.
- o_inCmd is 0 in IDLE, LEN and DONE.
- Latency: header byte to first memory write is 2 edges. Last payload byte accepted to o_done is 2 cycles without checksum, and 2 cycles after the checksum byte with it.
- Source stalls (s_valid=0) in DATA: hold state and outputs. The memory rewrites the same byte; this is benign.
- Length 256 starting at BASE_ADDR 8'h80 wraps: addresses 8'h80..8'hFF, then 8'h00..8'h7F.

Optional Feature:
- Macro: IM_LOADER_CSUM_EN.
- Defined: CSUM state present; one trailing checksum byte is expected; o_err is reported.
- Undefined: no CSUM state; DATA goes directly to FLUSH; no sum register; o_err is tied 0.

Decomposition:
- Shared header im_defs.vh: IM_ADDR_W=8, IM_DATA_W=8, IM_DEPTH=256.
- Loader state encodings (IDLE, LEN, DATA, CSUM, FLUSH, DONE) also go in im_defs.vh as localparams.
- Single module. The checksum accumulator is too small to split out, so no sub-module.

Test Plan:
- Reset, then start, then bytes 03,A1,B2,C3 with continuous valid:
  - Memory[0..2] = A1,B2,C3.
  - o_inCmd high from the A1 accept through FLUSH.
  - o_done pulses 2 cycles after the C3 accept.
  - memory[3] stays FF.
- Same frame with s_valid toggled every other cycle -> identical memory contents. o_addr/o_inst never change without an accept.
- BASE_ADDR=8'hFE, length 04, data 11,22,33,44 -> memory[FE],[FF],[00],[01] = 11,22,33,44.
- IM_LOADER_CSUM_EN defined:
  - Frame 02,10,20,checksum 30 -> o_err=0.
  - Checksum 31 -> o_err=1 and stays 1 until the next start.
- Length 00 -> 256 bytes accepted, all 256 addresses written, exactly one o_done pulse.
- rst asserted low after 2 of 3 data bytes -> o_inCmd=0 and s_ready=0 immediately. After rst release: state IDLE, and a fresh load succeeds.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared instruction-memory geometry and loader state encodings for im_loader.
package im_loader_pkg;
    localparam int IM_ADDR_W = 8;
    localparam int IM_DATA_W = 8;
    localparam int IM_DEPTH  = 256;
    // Remaining-byte counter must hold IM_DEPTH itself (length byte 0 means a full image).
    localparam int CNT_W     = $clog2(IM_DEPTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } ld_state_t;
endpackage

// File: rtl/im_loader.sv
// Framed byte-stream loader driving the instruction-memory load port.
// Define IM_LOADER_CSUM_EN to expect a trailing checksum byte and report o_err.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int                ADDR_W    = IM_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    input  logic [IM_DATA_W-1:0] s_data,
    output logic                 s_ready,
    output logic                 o_inCmd,
    output logic [ADDR_W-1:0]    o_addr,
    output logic [IM_DATA_W-1:0] o_inst,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    ld_state_t        state;
    logic [CNT_W-1:0] remaining;
    logic             first;
    logic             xfer;

    assign xfer = s_valid && s_ready;

`ifdef IM_LOADER_CSUM_EN
    logic [IM_DATA_W-1:0] sum;
`else
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            s_ready   <= 1'b0;
            o_inCmd   <= 1'b0;
            o_addr    <= BASE_ADDR;
            o_inst    <= '1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            remaining <= '0;
            first     <= 1'b0;
`ifdef IM_LOADER_CSUM_EN
            sum       <= '0;
            o_err     <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state   <= ST_LEN;
                    s_ready <= 1'b1;
                    o_busy  <= 1'b1;
`ifdef IM_LOADER_CSUM_EN
                    sum     <= '0;
                    o_err   <= 1'b0;
`endif
                end
                ST_LEN: if (xfer) begin
                    remaining <= (s_data == '0) ? CNT_W'(IM_DEPTH) : CNT_W'(s_data);
                    first     <= 1'b1;
                    state     <= ST_DATA;
                end
                // Address/data move only on an accept, so stalls just rewrite the same byte.
                ST_DATA: if (xfer) begin
                    o_addr    <= first ? BASE_ADDR : o_addr + ADDR_W'(1);
                    o_inst    <= s_data;
                    o_inCmd   <= 1'b1;
                    first     <= 1'b0;
                    remaining <= remaining - CNT_W'(1);
`ifdef IM_LOADER_CSUM_EN
                    sum       <= sum + s_data;
                    if (remaining == CNT_W'(1))
                        state <= ST_CSUM;
`else
                    if (remaining == CNT_W'(1)) begin
                        state   <= ST_FLUSH;
                        s_ready <= 1'b0;
                    end
`endif
                end
`ifdef IM_LOADER_CSUM_EN
                ST_CSUM: if (xfer) begin
                    if (s_data != sum)
                        o_err <= 1'b1;
                    state   <= ST_FLUSH;
                    s_ready <= 1'b0;
                end
`endif
                // One extra cycle of o_inCmd commits the final payload byte.
                ST_FLUSH: begin
                    o_inCmd <= 1'b0;
                    o_done  <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                    o_inCmd <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: two instances (base 00 and FE) checked every cycle against a byte-count model.
module tb_im_loader;
    localparam int CS =
`ifdef IM_LOADER_CSUM_EN
        1;
`else
        0;
`endif

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst, start, s_valid;
    logic [7:0] s_data;
    logic [1:0] rdy, cmd, bsy, dn, er;
    logic [1:0][7:0] addr, inst;

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(rdy[0]), .o_inCmd(cmd[0]), .o_addr(addr[0]), .o_inst(inst[0]),
        .o_busy(bsy[0]), .o_done(dn[0]), .o_err(er[0]));

    im_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(rdy[1]), .o_inCmd(cmd[1]), .o_addr(addr[1]), .o_inst(inst[1]),
        .o_busy(bsy[1]), .o_done(dn[1]), .o_err(er[1]));

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int clr_gen = 0;
    int clr_seen = 0;

    // model state: bytes of the frame consumed and cycles since the frame completed
    bit         m_active, m_err;
    int         m_pos, m_total, m_n, m_tail;
    logic [7:0] m_sum, m_inst;
    logic [7:0] m_addr [2];
    logic [7:0] mem [2][256];

    function automatic logic [7:0] base_of(input int b);
        return (b == 1) ? 8'hFE : 8'h00;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tfail(input string nm);
        n_total++;
        n_bad++;
        $display("FAIL %s got=timeout want=completion", nm);
    endtask

    task automatic m_reset();
        m_active = 0; m_err = 0; m_pos = 0; m_total = 1; m_n = 0; m_tail = 0;
        m_sum = 8'h00; m_inst = 8'hFF;
        for (int b = 0; b < 2; b++) m_addr[b] = base_of(b);
    endtask

    task automatic m_step();
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_pos = 0; m_total = 1; m_tail = 0; m_sum = 8'h00; m_err = 0;
            end
        end else if (m_pos < m_total) begin
            if (s_valid) begin
                if (m_pos == 0) begin
                    m_n = (s_data == 8'h00) ? 256 : int'(s_data);
                    m_total = 1 + m_n + CS;
                end else if (m_pos <= m_n) begin
                    m_inst = s_data;
                    m_sum  = m_sum + s_data;
                    for (int b = 0; b < 2; b++) m_addr[b] = base_of(b) + 8'(m_pos - 1);
                end else begin
                    m_err = (s_data != m_sum);
                end
                m_pos++;
            end
        end else begin
            m_tail++;
            if (m_tail == 2) m_active = 0;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model + memory emulation: memory takes o_inst at o_addr on each edge while o_inCmd is high.
    initial begin
        for (int b = 0; b < 2; b++) for (int a = 0; a < 256; a++) mem[b][a] = 8'hFF;
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (clr_gen != clr_seen) begin
                for (int b = 0; b < 2; b++) for (int a = 0; a < 256; a++) mem[b][a] = 8'hFF;
                clr_seen = clr_gen;
            end
            if (!rst) m_reset();
            else begin
                for (int b = 0; b < 2; b++) if (cmd[b]) mem[b][addr[b]] = inst[b];
                m_step();
            end
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                chk($sformatf("s_ready[%0d]@%0d", b, cyc), int'(rdy[b]), int'(m_active && m_pos < m_total));
                chk($sformatf("o_inCmd[%0d]@%0d", b, cyc), int'(cmd[b]), int'(m_active && m_pos >= 2 && m_tail == 0));
                chk($sformatf("o_busy[%0d]@%0d", b, cyc), int'(bsy[b]), int'(m_active));
                chk($sformatf("o_done[%0d]@%0d", b, cyc), int'(dn[b]), int'(m_active && m_tail == 1));
                chk($sformatf("o_err[%0d]@%0d", b, cyc), int'(er[b]), int'(m_err));
                chk($sformatf("o_addr[%0d]@%0d", b, cyc), int'(addr[b]), int'(m_addr[b]));
                chk($sformatf("o_inst[%0d]@%0d", b, cyc), int'(inst[b]), int'(m_inst));
            end
            if (dn[0]) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "watchdog");
    end

    function automatic bq_t frame_of(input bq_t pay, input bit bad_cs);
        bq_t f;
        logic [7:0] s = 8'h00;
        f.push_back(8'(pay.size()));
        foreach (pay[i]) begin
            f.push_back(pay[i]);
            s = s + pay[i];
        end
        if (CS == 1) f.push_back(bad_cs ? (s ^ 8'h01) : s);
        return f;
    endfunction

    function automatic bq_t rand_pay(input int n);
        bq_t p;
        repeat (n) p.push_back(8'($urandom));
        return p;
    endfunction

    // Tasks start and end at posedge+1.
    task automatic clear_mem();
        clr_gen++;
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: valid every other cycle, 2: random valid plus stray start pulses
    task automatic send(input bq_t fr, input int mode, output int last_cyc);
        int  idx = 0;
        int  budget = 0;
        bit  tog = 1'b0;
        bit  acc;
        last_cyc = 0;
        s_valid = 1'b0;
        while (idx < fr.size()) begin
            if (!s_valid) begin
                case (mode)
                    0: s_valid = 1'b1;
                    1: begin s_valid = tog; tog = !tog; end
                    default: s_valid = ($urandom_range(0, 3) != 0);
                endcase
                s_data = s_valid ? fr[idx] : 8'($urandom);
            end
            if (mode == 2) start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc = s_valid && rdy[0];
            if (acc) last_cyc = cyc;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                s_valid = 1'b0;
            end
            budget++;
            if (budget > 4 * fr.size() + 20) begin
                tfail("send_budget");
                break;
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (bsy[0] || bsy[1]) begin
            @(posedge clk); #1;
            k++;
            if (k > 40) begin
                tfail(nm);
                break;
            end
        end
    endtask

    task automatic check_mem(input bq_t pay, input string nm);
        for (int b = 0; b < 2; b++)
            foreach (pay[i])
                chk($sformatf("%s_mem%0d[%0h]", nm, b, 8'(base_of(b) + 8'(i))),
                    int'(mem[b][8'(base_of(b) + 8'(i))]), int'(pay[i]));
    endtask

    initial begin
        bq_t pay;
        int  lc;
        int  d0;
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(rdy), 0);
        chk("rst_busy", int'(bsy), 0);
        chk("rst_addr1", int'(addr[1]), 'hFE);
        chk("rst_inst0", int'(inst[0]), 'hFF);

        // 03 A1 B2 C3, continuous valid
        pay = '{8'hA1, 8'hB2, 8'hC3};
        pulse_start();
        send(frame_of(pay, 1'b0), 0, lc);
        wait_idle("t1_idle");
        chk("t1_mem0_0", int'(mem[0][0]), 'hA1);
        chk("t1_mem0_1", int'(mem[0][1]), 'hB2);
        chk("t1_mem0_2", int'(mem[0][2]), 'hC3);
        chk("t1_mem0_3", int'(mem[0][3]), 'hFF);
        chk("t1_mem1_FE", int'(mem[1][8'hFE]), 'hA1);
        chk("t1_mem1_00", int'(mem[1][8'h00]), 'hC3);
        chk("t1_mem1_01", int'(mem[1][8'h01]), 'hFF);
        chk("t1_done_lat", last_done_cyc - lc, 2);

        // same frame, valid toggling every other cycle
        clear_mem();
        pulse_start();
        send(frame_of(pay, 1'b0), 1, lc);
        wait_idle("t2_idle");
        check_mem(pay, "t2");
        chk("t2_mem0_3", int'(mem[0][3]), 'hFF);

        // 4-byte frame crosses FF->00 on the FE-based loader
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        clear_mem();
        pulse_start();
        send(frame_of(pay, 1'b0), 2, lc);
        wait_idle("t3_idle");
        chk("t3_mem1_FF", int'(mem[1][8'hFF]), 'h22);
        chk("t3_mem1_01", int'(mem[1][8'h01]), 'h44);
        check_mem(pay, "t3");

        // checksum 30 good, 31 bad; o_err sticky until next start
        pay = '{8'h10, 8'h20};
        pulse_start();
        send(frame_of(pay, 1'b0), 0, lc);
        wait_idle("cs_good_idle");
        chk("cs_good_err", int'(er[0]), 0);
        pulse_start();
        send(frame_of(pay, 1'b1), 0, lc);
        wait_idle("cs_bad_idle");
        chk("cs_bad_err0", int'(er[0]), CS);
        repeat (3) @(posedge clk);
        #1 chk("cs_bad_sticky1", int'(er[1]), CS);
        pulse_start();
        chk("cs_clear_on_start", int'(er[0]), 0);
        send(frame_of(pay, 1'b0), 0, lc);
        wait_idle("cs_clear_idle");

        // random frames with random stalls and stray start pulses
        for (int k = 0; k < 6; k++) begin
            pay = rand_pay($urandom_range(1, 24));
            clear_mem();
            pulse_start();
            send(frame_of(pay, 1'($urandom_range(0, 1))), 2, lc);
            wait_idle("rnd_idle");
            check_mem(pay, $sformatf("rnd%0d", k));
        end

        // length byte 00 -> full 256-byte image
        pay = rand_pay(256);
        d0 = done_cnt;
        clear_mem();
        pulse_start();
        send(frame_of(pay, 1'b0), 2, lc);
        wait_idle("l256_idle");
        check_mem(pay, "l256");
        chk("l256_done_pulses", done_cnt - d0, 1);

        // reset after 2 of 3 data bytes: second byte never gets its write edge
        clear_mem();
        pulse_start();
        send('{8'h03, 8'h5A, 8'h6B}, 0, lc);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ready", int'(rdy), 0);
        chk("mid_rst_cmd", int'(cmd), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", int'(bsy), 0);
        chk("mid_rst_addr1", int'(addr[1]), 'hFE);
        chk("mid_mem0_0", int'(mem[0][0]), 'h5A);
        chk("mid_mem0_1", int'(mem[0][1]), 'hFF);
        chk("mid_mem1_FF", int'(mem[1][8'hFF]), 'hFF);
        pay = rand_pay(5);
        clear_mem();
        pulse_start();
        send(frame_of(pay, 1'b0), 0, lc);
        wait_idle("post_rst_idle");
        check_mem(pay, "post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
